// File: rtl/lcd_w_pkg.sv
// Shared definitions for the LCD W'/W shift unit: command opcodes, segment PLA and length clamp.
package lcd_w_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_WR   = 3'd1,
    OP_WS   = 3'd2,
    OP_DTW  = 3'd3,
    OP_PDTW = 3'd4,
    OP_PTW  = 3'd5,
    OP_TW   = 3'd6,
    OP_CLR  = 3'd7
  } cmd_op_e;

  // Entry k sits in bits [4k+3:4k]; k = {cn, acc}.
  localparam logic [127:0] PLA_TABLE = 128'h04ed04ffbeedf79b22a200ae2ea28c0e;

  function automatic logic [3:0] pla_digit(input logic cn, input logic [3:0] acc,
                                           input logic m_prime);
    logic [3:0] d;
    d    = PLA_TABLE[{cn, acc, 2'b00} +: 4];
    d[0] = d[0] | (~cn & m_prime);
    return d;
  endfunction

  function automatic logic [3:0] clamp_len(input logic [3:0] w, input logic [3:0] max_len);
    logic [3:0] l;
    if (w < 4'd2)        l = 4'd2;
    else if (w > max_len) l = max_len;
    else                 l = w;
    return l;
  endfunction

endpackage

// File: rtl/lcd_w_shift_unit_scan_fsm.sv
// Scan-out sequencer: walks W from index 0 to len-1 under a valid/ready handshake.
//   state | meaning
//   IDLE  | no frame in flight, commands may be accepted
//   SCAN  | presenting W[idx], advancing on each accepted beat
module lcd_w_scan_fsm #(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       len,
  input  logic             scan_ready,
  output logic             busy,
  output logic             scan_valid,
  output logic [IDX_W-1:0] scan_index,
  output logic             frame_done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  scan_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             fd_q, fd_d;
  logic             last_beat;

  assign last_beat = (int'(idx_q) == int'(len) - 1);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    fd_d       = 1'b0;
    scan_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SCAN;
          idx_d   = '0;
        end
      end
      ST_SCAN: begin
        scan_valid = 1'b1;
        if (scan_ready) begin
          if (last_beat) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            fd_d    = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fd_q    <= fd_d;
    end
  end

  assign busy       = (state_q == ST_SCAN);
  assign scan_index = idx_q;
  assign frame_done = fd_q;

endmodule

// File: rtl/lcd_w_shift_unit.sv
// W' staging shift register and W display register with variable active length,
// plus handshaked scan-out of W to the LCD segment driver.
module lcd_w_shift_unit
  import lcd_w_pkg::*;
#(
  parameter int MAX_DIGITS = 9,
  localparam int IDX_W = $clog2(MAX_DIGITS)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_op,
  input  logic [3:0]              acc,
  input  logic                    lcd_cn,
  input  logic                    m_prime,
  input  logic [3:0]              w_length,
  output logic [4*MAX_DIGITS-1:0] w_out,
  output logic                    scan_valid,
  input  logic                    scan_ready,
  output logic [IDX_W-1:0]        scan_index,
  output logic [3:0]              scan_digit,
  output logic                    frame_done
);

  localparam logic [3:0] MAX_LEN = 4'(MAX_DIGITS);

  logic [3:0] wp_q [MAX_DIGITS];
  logic [3:0] wp_d [MAX_DIGITS];
  logic [3:0] w_q  [MAX_DIGITS];
  logic [3:0] w_d  [MAX_DIGITS];
  logic [3:0] len_q, len_d;

  cmd_op_e    op;
  logic       accept;
  logic       start_scan;
  logic       busy;
  logic [3:0] len_now;
  logic [3:0] pla_d;
  logic [3:0] shift_val;
  int         len_i;

  assign op         = cmd_op_e'(cmd_op);
  assign cmd_ready  = ~busy;
  assign accept     = cmd_valid & cmd_ready;
  assign start_scan = accept & ((op == OP_PTW) | (op == OP_TW));
  assign len_now    = clamp_len(w_length, MAX_LEN);
  assign pla_d      = pla_digit(lcd_cn, acc, m_prime);

  always_comb begin
    case (op)
      OP_WR:   shift_val = {1'b0, acc[2:0]};
      OP_WS:   shift_val = {1'b1, acc[2:0]};
      default: shift_val = pla_d;
    endcase
  end

  // Length is taken from w_length on the accepting cycle; len_q keeps it for the scan.
  always_comb begin
    wp_d  = wp_q;
    w_d   = w_q;
    len_d = len_q;
    len_i = int'(len_now);
    if (accept) begin
      len_d = len_now;
      case (op)
        OP_WR, OP_WS, OP_DTW: begin
          for (int i = 0; i < MAX_DIGITS - 1; i++)
            if (i < len_i - 1) wp_d[i] = wp_q[i+1];
          for (int i = 0; i < MAX_DIGITS; i++)
            if (i == len_i - 1) wp_d[i] = shift_val;
        end
        OP_PDTW: begin
          for (int i = 0; i < MAX_DIGITS - 1; i++)
            if (i == len_i - 2) wp_d[i] = wp_q[i+1];
          for (int i = 0; i < MAX_DIGITS; i++)
            if (i == len_i - 1) wp_d[i] = pla_d;
        end
        OP_PTW: begin
          for (int i = 0; i < MAX_DIGITS; i++)
            if ((i == len_i - 1) || (i == len_i - 2)) w_d[i] = wp_q[i];
        end
        OP_TW: begin
          for (int i = 0; i < MAX_DIGITS; i++)
            if (i < len_i) w_d[i] = wp_q[i];
        end
        OP_CLR: begin
          for (int i = 0; i < MAX_DIGITS; i++) wp_d[i] = 4'h0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_DIGITS; i++) begin
        wp_q[i] <= 4'h0;
        w_q[i]  <= 4'h0;
      end
      len_q <= 4'd2;
    end else begin
      wp_q  <= wp_d;
      w_q   <= w_d;
      len_q <= len_d;
    end
  end

  always_comb begin
    w_out = '0;
    for (int i = 0; i < MAX_DIGITS; i++) w_out[4*i +: 4] = w_q[i];
  end

  assign scan_digit = w_q[scan_index];

  lcd_w_scan_fsm #(.IDX_W(IDX_W)) u_scan_fsm (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start_scan),
    .len        (len_q),
    .scan_ready (scan_ready),
    .busy       (busy),
    .scan_valid (scan_valid),
    .scan_index (scan_index),
    .frame_done (frame_done)
  );

endmodule

// File: tb/tb_lcd_w_shift_unit.sv
// Self-checking bench for lcd_w_shift_unit: per-cycle comparison against a queue-based model plus literal pins.
`timescale 1ns/1ps
module tb_lcd_w_shift_unit;

  localparam logic [2:0] C_NOP = 3'd0, C_WR = 3'd1, C_WS = 3'd2, C_DTW = 3'd3,
                         C_PDTW = 3'd4, C_PTW = 3'd5, C_TW = 3'd6, C_CLR = 3'd7;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = 3'd0;
  logic [3:0]  acc = 4'd0;
  logic        lcd_cn = 1'b0;
  logic        m_prime = 1'b0;
  logic [3:0]  w_length = 4'd9;
  logic        scan_ready = 1'b1;
  logic        cmd_ready;
  logic [35:0] w_out;
  logic        scan_valid;
  logic [3:0]  scan_index;
  logic [3:0]  scan_digit;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  lcd_w_shift_unit #(.MAX_DIGITS(9)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .acc        (acc),
    .lcd_cn     (lcd_cn),
    .m_prime    (m_prime),
    .w_length   (w_length),
    .w_out      (w_out),
    .scan_valid (scan_valid),
    .scan_ready (scan_ready),
    .scan_index (scan_index),
    .scan_digit (scan_digit),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Behavioural model: W'/W as plain arrays, the pending frame as a queue of digits.
  logic [3:0] pla_tab [32] = '{4'he, 4'h0, 4'hc, 4'h8, 4'h2, 4'ha, 4'he, 4'h2,
                               4'he, 4'ha, 4'h0, 4'h0, 4'h2, 4'ha, 4'h2, 4'h2,
                               4'hb, 4'h9, 4'h7, 4'hf, 4'hd, 4'he, 4'he, 4'hb,
                               4'hf, 4'hf, 4'h4, 4'h0, 4'hd, 4'he, 4'h4, 4'h0};
  int mwp [9];
  int mw  [9];
  int mq  [$];
  int mbeat = 0;
  bit mfd = 1'b0;

  function automatic int clampl(int w);
    if (w < 2) return 2;
    if (w > 9) return 9;
    return w;
  endfunction

  function automatic logic [35:0] pack_w();
    logic [35:0] r;
    for (int i = 0; i < 9; i++) r[4*i +: 4] = 4'(mw[i]);
    return r;
  endfunction

  always @(posedge clk) begin
    int l;
    int d;
    if (!reset_n) begin
      for (int i = 0; i < 9; i++) begin mwp[i] = 0; mw[i] = 0; end
      mq.delete();
      mbeat = 0;
      mfd = 1'b0;
    end else begin
      mfd = 1'b0;
      if (mq.size() != 0) begin
        if (scan_ready) begin
          void'(mq.pop_front());
          mbeat++;
          if (mq.size() == 0) begin mfd = 1'b1; mbeat = 0; end
        end
      end else if (cmd_valid) begin
        l = clampl(int'(w_length));
        d = int'(pla_tab[{lcd_cn, acc}]) | ((!lcd_cn && m_prime) ? 1 : 0);
        case (cmd_op)
          C_WR, C_WS, C_DTW: begin
            for (int i = 0; i < l - 1; i++) mwp[i] = mwp[i+1];
            if (cmd_op == C_WR)      mwp[l-1] = int'(acc[2:0]);
            else if (cmd_op == C_WS) mwp[l-1] = 8 + int'(acc[2:0]);
            else                     mwp[l-1] = d;
          end
          C_PDTW: begin mwp[l-2] = mwp[l-1]; mwp[l-1] = d; end
          C_PTW: begin
            mw[l-1] = mwp[l-1]; mw[l-2] = mwp[l-2];
            for (int i = 0; i < l; i++) mq.push_back(mw[i]);
          end
          C_TW: begin
            for (int i = 0; i < l; i++) mw[i] = mwp[i];
            for (int i = 0; i < l; i++) mq.push_back(mw[i]);
          end
          C_CLR: for (int i = 0; i < 9; i++) mwp[i] = 0;
          default: ;
        endcase
      end
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_cmd_ready", 64'(cmd_ready), 64'(mq.size() == 0));
      chk("cyc_scan_valid", 64'(scan_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("cyc_scan_index", 64'(scan_index), 64'(mbeat));
        chk("cyc_scan_digit", 64'(scan_digit), 64'(mq[0]));
      end
      chk("cyc_frame_done", 64'(frame_done), 64'(mfd));
      chk("cyc_w_out", 64'(w_out), 64'(pack_w()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(logic [2:0] op, logic [3:0] a, logic cn = 1'b0, logic m = 1'b0);
    cmd_valid = 1'b1; cmd_op = op; acc = a; lcd_cn = cn; m_prime = m;
    tick();
    cmd_valid = 1'b0; cmd_op = C_NOP;
  endtask

  task automatic run_frame(string name, int exp_beats);
    int n = 0;
    while (mq.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk({name, "_beats"}, 64'(n), 64'(exp_beats));
    chk({name, "_frame_done"}, 64'(frame_done), 64'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    tick(); tick();
    chk("rst_w_out", 64'(w_out), 64'd0);
    chk("rst_scan_valid", 64'(scan_valid), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_scan_index", 64'(scan_index), 64'd0);
    reset_n = 1'b1;
    chk_en = 1'b1;

    // WS/WR shifting and full TW frame at L=9
    w_length = 4'd9; scan_ready = 1'b1;
    cmd(C_WS, 4'd5);
    cmd(C_WR, 4'd3);
    cmd(C_TW, 4'd0);
    chk("shift_w_out", 64'(w_out), 64'h3D0000000);
    run_frame("shift", 9);

    // PLA lookups
    cmd(C_CLR, 4'd0);
    cmd(C_DTW, 4'd3, 1'b0, 1'b0);
    cmd(C_DTW, 4'd3, 1'b0, 1'b1);
    cmd(C_DTW, 4'd0, 1'b1, 1'b1);
    cmd(C_TW, 4'd0);
    chk("pla_w_out", 64'(w_out), 64'hB98000000);
    run_frame("pla", 9);

    // PDTW / PTW at L=4
    cmd(C_CLR, 4'd0);
    w_length = 4'd4;
    cmd(C_WR, 4'd1); cmd(C_WR, 4'd2); cmd(C_WR, 4'd3); cmd(C_WR, 4'd4);
    cmd(C_PDTW, 4'd0, 1'b0, 1'b0);
    cmd(C_PTW, 4'd0);
    chk("ptw_w_out", 64'(w_out), 64'hB9800E400);
    run_frame("ptw", 4);

    // Backpressure at L=3 with a competing TW that must be dropped
    w_length = 4'd3; scan_ready = 1'b0;
    cmd(C_TW, 4'd0);
    cmd_valid = 1'b1; cmd_op = C_TW;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_scan_index", 64'(scan_index), 64'd0);
      chk("bp_scan_digit", 64'(scan_digit), 64'h1);
      chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    cmd_valid = 1'b0; cmd_op = C_NOP; scan_ready = 1'b1;
    run_frame("bp", 3);
    chk("bp_w_out", 64'(w_out), 64'hB9800E421);
    tick();
    chk("bp_no_requeue", 64'(scan_valid), 64'd0);

    // Length clamping
    w_length = 4'd1;
    cmd(C_TW, 4'd0);
    run_frame("clamp_lo", 2);
    w_length = 4'd15;
    cmd(C_TW, 4'd0);
    run_frame("clamp_hi", 9);
    chk("clamp_hi_w_out", 64'(w_out), 64'h00000E421);

    // w_length change during a frame
    w_length = 4'd4;
    cmd(C_TW, 4'd0);
    w_length = 4'd2;
    run_frame("midlen", 4);

    // Reset at scan beat 2
    w_length = 4'd9;
    cmd(C_TW, 4'd0);
    tick(); tick();
    chk("rstmid_index", 64'(scan_index), 64'd2);
    reset_n = 1'b0;
    tick();
    chk("rstmid_scan_valid", 64'(scan_valid), 64'd0);
    chk("rstmid_frame_done", 64'(frame_done), 64'd0);
    chk("rstmid_w_out", 64'(w_out), 64'd0);
    reset_n = 1'b1;
    tick();
    chk("rstmid_after_fd", 64'(frame_done), 64'd0);
    chk("rstmid_after_ready", 64'(cmd_ready), 64'd1);
    tick();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_w_shift_unit.md
Name: lcd_w_shift_unit

Overview:
- Parametrised successor to the fixed 9-entry W'/W nibble registers in the SM5a instruction path.
- Holds the W' staging shift register and the W display register, with a runtime-selectable active length, and executes the WR/WS/DTW/PDTW/PTW/TW operations.
- Adds a handshaked scan-out FSM that streams W to the LCD segment driver one digit per transfer after every W update.
- Sits between the CPU instruction decoder (command side) and the LCD segment driver (scan side).

Parameters:
- MAX_DIGITS, 9, number of W'/W nibble entries implemented (legal range 2..15).
- IDX_W, $clog2(MAX_DIGITS), width of the scan index; derived, not overridden.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command strobe.
- cmd_ready  out  1  command accept; low while scanning.
- cmd_op  in  3  opcode; encodings in shared package.
- acc  in  4  CPU accumulator value.
- lcd_cn  in  1  CN flag; selects the PLA half.
- m_prime  in  1  m' flag.
- w_length  in  4  active digit count; sampled when a command is accepted.
- w_out  out  4*MAX_DIGITS  W contents, flattened; entry i occupies bits [4i+3:4i].
- scan_valid  out  1  scan digit valid.
- scan_ready  in  1  LCD driver accept.
- scan_index  out  IDX_W  index of the current scan digit.
- scan_digit  out  4  W[scan_index].
- frame_done  out  1  one-cycle pulse after the last scan beat.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - All W'/W entries = 0.
  - FSM = IDLE; scan_valid=0, frame_done=0, scan_index=0, cmd_ready=1.
  - Reset applied mid-scan aborts the scan; no frame_done is issued.
- Effective length L = clamp(w_length, 2, MAX_DIGITS), latched into len_q on each accepted command. Changes to w_length mid-scan are ignored.
- A command is accepted when cmd_valid && cmd_ready. Its effect is visible on the next cycle. cmd_valid while not ready is ignored (dropped, not queued).
- PLA digit d = PLA[{lcd_cn, acc}] with bit 0 ORed by (~lcd_cn & m_prime). The PLA is a 32-entry constant.
- Shift (op with value v): for i < L-1, W'[i] <= W'[i+1]; W'[L-1] <= v. Entries with index >= L hold their value.
  - OP_NOP: no change.
  - OP_WR: shift with v = {1'b0, acc[2:0]}.
  - OP_WS: shift with v = {1'b1, acc[2:0]}.
  - OP_DTW: shift with v = d.
  - OP_PDTW: W'[L-2] <= W'[L-1]; W'[L-1] <= d. Other entries hold.
  - OP_PTW: W[L-1] <= W'[L-1]; W[L-2] <= W'[L-2]; then start scan.
  - OP_TW: W[i] <= W'[i] for all i < L; then start scan.
  - OP_CLR: all W' entries = 0; W is untouched.
- Scan FSM:
  - IDLE → SCAN on acceptance of PTW or TW. SCAN is entered the next cycle with scan_index=0.
  - In SCAN: scan_valid=1, scan_digit=W[scan_index], cmd_ready=0.
  - On scan_valid && scan_ready with scan_index < len_q-1: scan_index increments.
  - On the handshake with scan_index = len_q-1: go to IDLE, pulse frame_done on the next cycle, reset scan_index to 0.
  - scan_ready held low stalls indefinitely; scan_digit stays stable.
  - Latency from accept to first scan_valid = 1 cycle. A full frame with scan_ready tied high takes L cycles.
- W is only written in IDLE (PTW/TW cannot be accepted during SCAN), so scan data is coherent.

Decomposition:
- Shared package lcd_w_pkg holds:
  - cmd_op enum: NOP=0, WR=1, WS=2, DTW=3, PDTW=4, PTW=5, TW=6, CLR=7.
  - The 32-entry PLA constant: e,0,c,8,2,a,e,2,e,a,0,0,2,a,2,2,b,9,7,f,d,e,e,b,f,f,4,0,d,e,4,0.
  - Function pla_digit(cn, acc, m_prime).
- One natural sub-module: lcd_w_scan_fsm (IDLE/SCAN state, index counter, frame_done). Register arrays and op decode stay in the top module.

Test Plan:
- Reset: after reset_n=0 for 2 cycles → w_out=0, scan_valid=0, cmd_ready=1.
- Shift: L=9; WS acc=5, then WR acc=3 → W'[7]=0xD, W'[8]=0x3. TW → w_out[8]=3, [7]=D, all others 0. 9 scan beats with scan_ready=1, then frame_done one cycle later.
- PLA: DTW with acc=3, cn=0, m'=0 shifts in 0x8. With m'=1 it shifts in 0x9. acc=0, cn=1, m'=1 shifts in 0xB (m' ignored).
- PDTW with L=4, W'=[1,2,3,4] (index 0..3) and d=0xE → W'=[1,2,4,E]. PTW → W[2]=4, W[3]=E, W[0..1] unchanged.
- Backpressure: start TW with L=3 and scan_ready low for 5 cycles → scan_index=0 and scan_digit stable throughout. cmd_valid=TW asserted meanwhile is not accepted.
- Edge cases:
  - w_length=1 clamps to L=2; w_length=15 clamps to MAX_DIGITS.
  - reset_n=0 at scan beat 2 → next cycle IDLE, scan_valid=0, no frame_done.
  - w_length changed mid-scan → beat count unchanged.
